// File: rtl/key_pkg.sv
// Shared types and constants for the key debounce/capture front-end.
// Sized for pairing with encoder8x3.
package key_pkg;

   localparam int NUM_KEYS        = 8;
   localparam int DEB_CNT_DEFAULT = 4;

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   // Isolate the lowest set bit: two's-complement trick, v & -v.
   function automatic logic [NUM_KEYS-1:0] lowest_one_hot(input logic [NUM_KEYS-1:0] v);
      return v & (~v + {{(NUM_KEYS-1){1'b0}}, 1'b1});
   endfunction

endpackage

// File: rtl/key_debounce_capture_if.sv
// Key capture bus: raw keys and ack in, held one-hot key, enable and overrun out.
// The slave modport is the capture block; the master modport is the environment.
interface key_debounce_capture_if;
   import key_pkg::*;

   logic [NUM_KEYS-1:0] key_in;
   logic                ack;
   logic [NUM_KEYS-1:0] a;
   logic                en;
   logic                overrun;

   modport master (output key_in, ack, input a, en, overrun);
   modport slave  (input key_in, ack, output a, en, overrun);

endinterface

// File: rtl/key_debounce_capture_debounce_bit.sv
// One key channel: 2-flop synchronizer followed by a consecutive-cycle debounce counter.
// dout only changes after the synchronized input differs from it for DEB_CNT edges.
module debounce_bit #(
   parameter int DEB_CNT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam int CW = $clog2(DEB_CNT + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // NOTE: non-blocking (<=) so every flop samples pre-edge values; the sync chain and
   // the counter compare rely on seeing the previous cycle's sync2, not the new one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         dout  <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         if (sync2 == dout) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB_CNT - 1)) begin
            dout <= sync2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_debounce_capture.sv
// Debounces eight keys, captures the lowest newly pressed key as a held one-hot word
// for encoder8x3, and releases it on ack. Presses that cannot be captured raise overrun.
module key_debounce_capture
   import key_pkg::*;
#(
   parameter int DEB_CNT = DEB_CNT_DEFAULT
) (
   input logic                   clk,
   input logic                   rst,
   key_debounce_capture_if.slave bus
);

   logic [NUM_KEYS-1:0] deb;
   logic [NUM_KEYS-1:0] deb_prev;
   logic [NUM_KEYS-1:0] rise;
   state_t              state;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_deb
      debounce_bit #(.DEB_CNT(DEB_CNT)) u_deb (
         .clk  (clk),
         .rst  (rst),
         .din  (bus.key_in[i]),
         .dout (deb[i])
      );
   end

   // Releases (falling deb) deliberately produce nothing.
   assign rise = deb & ~deb_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb_prev    <= '0;
         state       <= IDLE;
         bus.a       <= '0;
         bus.en      <= 1'b0;
         bus.overrun <= 1'b0;
      end else begin
         deb_prev    <= deb;
         bus.overrun <= 1'b0;
         case (state)
            IDLE: begin
               if (rise != '0) begin
                  bus.a       <= lowest_one_hot(rise);
                  bus.en      <= 1'b1;
                  state       <= HOLD;
                  // More than one bit set means the others are dropped.
                  bus.overrun <= ((rise & (rise - 1'b1)) != '0);
               end
            end
            HOLD: begin
               if (rise != '0) bus.overrun <= 1'b1;
               if (bus.ack) begin
                  bus.a  <= '0;
                  bus.en <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_debounce_capture.sv
// Bench for key_debounce_capture: directed scenarios plus random key/ack traffic,
// all checked each cycle against an event-level reference model.
module tb_key_debounce_capture;
   import key_pkg::*;

   localparam int DEB = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   key_debounce_capture_if bus_if ();

   key_debounce_capture #(.DEB_CNT(DEB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: raw samples delayed two edges, a sliding window of synchronized
   // words, and a held key index (-1 = none).
   logic [7:0] kq[$];
   logic [7:0] sh[$];
   logic [7:0] m_deb;
   logic [7:0] m_rise;
   int         m_held;
   logic       m_ovr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_a();
      logic [7:0] r;
      r = '0;
      if (m_held >= 0) r[m_held] = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      kq     = '{8'h00, 8'h00};
      sh     = {};
      for (int j = 0; j < DEB; j++) sh.push_back(8'h00);
      m_deb  = '0;
      m_rise = '0;
      m_held = -1;
      m_ovr  = 1'b0;
   endtask

   task automatic model_step();
      logic [7:0] su;
      logic [7:0] nd;
      logic       all_diff;
      m_ovr = 1'b0;
      if (m_held < 0) begin
         if (m_rise != 0) begin
            for (int i = 7; i >= 0; i--) if (m_rise[i]) m_held = i;
            m_ovr = ($countones(m_rise) > 1);
         end
      end else begin
         if (m_rise != 0) m_ovr = 1'b1;
         if (bus_if.ack) m_held = -1;
      end
      su = kq.pop_front();
      kq.push_back(bus_if.key_in);
      sh.push_back(su);
      if (sh.size() > DEB) void'(sh.pop_front());
      nd = m_deb;
      for (int i = 0; i < 8; i++) begin
         all_diff = 1'b1;
         foreach (sh[j]) if (sh[j][i] == m_deb[i]) all_diff = 1'b0;
         if (all_diff) nd[i] = ~m_deb[i];
      end
      m_rise = nd & ~m_deb;
      m_deb  = nd;
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check({tag, "_a"}, 32'(bus_if.a), 32'(exp_a()));
      check({tag, "_en"}, 32'(bus_if.en), 32'(m_held >= 0));
      check({tag, "_ovr"}, 32'(bus_if.overrun), 32'(m_ovr));
      check({tag, "_inv"}, 32'(bus_if.en), 32'(bus_if.a != 0));
   endtask

   task automatic ticks(input string tag, input int n);
      for (int k = 0; k < n; k++) tick(tag);
   endtask

   task automatic do_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check({tag, "_rst_a"}, 32'(bus_if.a), 32'h0);
      check({tag, "_rst_en"}, 32'(bus_if.en), 32'h0);
      check({tag, "_rst_ovr"}, 32'(bus_if.overrun), 32'h0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic settle();
      bus_if.key_in = '0;
      bus_if.ack    = 1'b0;
      ticks("settle", 8);
   endtask

   task automatic ack_once();
      bus_if.ack = 1'b1;
      tick("ack");
      bus_if.ack = 1'b0;
   endtask

   int hold_left;

   initial begin
      bus_if.key_in = '0;
      bus_if.ack    = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      check("init_a", 32'(bus_if.a), 32'h0);
      check("init_en", 32'(bus_if.en), 32'h0);
      check("init_ovr", 32'(bus_if.overrun), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Clean press: capture on edge 7, held until ack.
      bus_if.key_in = 8'h20;
      ticks("clean", 6);
      check("clean_pre_en", 32'(bus_if.en), 32'h0);
      tick("clean");
      check("clean_cap_a", 32'(bus_if.a), 32'h20);
      check("clean_cap_en", 32'(bus_if.en), 32'h1);
      ticks("clean_hold", 3);
      check("clean_held_a", 32'(bus_if.a), 32'h20);
      ack_once();
      check("clean_rel_a", 32'(bus_if.a), 32'h0);
      check("clean_rel_en", 32'(bus_if.en), 32'h0);
      settle();

      // Bounce is rejected; a steady level then captures.
      bus_if.key_in = 8'h04; ticks("bounce", 3);
      bus_if.key_in = 8'h00; ticks("bounce", 2);
      bus_if.key_in = 8'h04; ticks("bounce", 3);
      check("bounce_en", 32'(bus_if.en), 32'h0);
      ticks("bounce", 6);
      check("bounce_cap_a", 32'(bus_if.a), 32'h04);
      ack_once();
      settle();

      // Simultaneous presses: lowest captured, one-cycle overrun, no re-presentation.
      bus_if.key_in = 8'h48;
      ticks("simul", 7);
      check("simul_a", 32'(bus_if.a), 32'h08);
      check("simul_ovr", 32'(bus_if.overrun), 32'h1);
      tick("simul");
      check("simul_ovr_end", 32'(bus_if.overrun), 32'h0);
      ack_once();
      ticks("simul_after", 10);
      check("simul_nocap", 32'(bus_if.en), 32'h0);
      settle();

      // Press while holding: dropped with overrun, never captured later.
      bus_if.key_in = 8'h01;
      ticks("hold", 7);
      check("hold_cap_a", 32'(bus_if.a), 32'h01);
      bus_if.key_in = 8'h03;
      ticks("hold", 6);
      check("hold_pre_ovr", 32'(bus_if.overrun), 32'h0);
      tick("hold");
      check("hold_ovr", 32'(bus_if.overrun), 32'h1);
      check("hold_keep_a", 32'(bus_if.a), 32'h01);
      ack_once();
      ticks("hold_after", 10);
      check("hold_nocap", 32'(bus_if.en), 32'h0);
      settle();

      // Reset while holding key 3; still-held key is re-captured after release.
      bus_if.key_in = 8'h08;
      ticks("rsth", 7);
      check("rsth_cap_a", 32'(bus_if.a), 32'h08);
      do_reset("rsth");
      ticks("rsth", 6);
      check("rsth_pre_en", 32'(bus_if.en), 32'h0);
      tick("rsth");
      check("rsth_recap_a", 32'(bus_if.a), 32'h08);
      ack_once();
      settle();

      // Reset with all keys down mid-debounce.
      bus_if.key_in = 8'hFF;
      ticks("rstf", 3);
      do_reset("rstf");
      ticks("rstf", 6);
      check("rstf_pre_en", 32'(bus_if.en), 32'h0);
      tick("rstf");
      check("rstf_a", 32'(bus_if.a), 32'h01);
      check("rstf_ovr", 32'(bus_if.overrun), 32'h1);
      ack_once();
      settle();

      // Random traffic with occasional asynchronous reset.
      hold_left = 0;
      for (int c = 0; c < 600; c++) begin
         if (hold_left == 0) begin
            bus_if.key_in = 8'($urandom & $urandom);
            hold_left = $urandom_range(1, 10);
         end
         hold_left--;
         bus_if.ack = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 199) == 0) do_reset("rnd");
         else tick("rnd");
      end
      settle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/key_debounce_capture.md
Name: key_debounce_capture

Overview:
- Upstream front-end for encoder8x3. Synchronizes and debounces eight raw push-button/switch lines.
- Detects debounced press (rising) events and captures exactly one key as a held one-hot word.
- Drives the encoder's a0..a7 and en, so the encoder only ever sees a single active input.
- Holds the captured key until the consumer acknowledges it.

Parameters:
- DEB_CNT, 4: consecutive clock cycles a synchronized input must differ from the debounced level before that level changes. Legal range ≥ 1.
- NUM_KEYS, 8: number of input channels. Fixed at 8 for the encoder8x3 pairing.

Ports:
- clk    input   1  system clock, rising-edge active
- rst    input   1  asynchronous, active-high reset
- key_in input   8  raw, asynchronous key levels, active high
- ack    input   1  consumer acknowledge; releases the held key
- a      output  8  one-hot captured key; bit i drives encoder input ai
- en     output  1  valid/enable to encoder; high while a key is held
- overrun output 1  one-cycle pulse: a press event was dropped

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values: sync flops 0, debounced levels 0, counters 0, deb_prev 0, a=8'h00, en=0, overrun=0, state IDLE. Assertion clears everything immediately, without waiting for a clock edge.
- Synchronizer: 2 flops per channel.
- Debounce, per channel:
  - if sync==deb, cnt<=0.
  - else if cnt==DEB_CNT-1, deb<=sync and cnt<=0.
  - else cnt<=cnt+1.
  - Counter width is clog2(DEB_CNT+1).
  - A sync change that persists DEB_CNT edges updates deb. Any reversion earlier restarts the count (glitch rejected).
- Press detect: deb_prev<=deb each edge; rise[i]=deb[i]&~deb_prev[i], combinational from registers.
- State machine, states IDLE and HOLD:
  - IDLE, rise!=0: on the edge, a<=one-hot of the lowest-index set bit of rise, en<=1, go HOLD. If more than one rise bit was set, overrun pulses on that same edge.
  - IDLE, rise==0: stay. ack is ignored.
  - HOLD: a and en are held. If ack is high on an edge, a<=0, en<=0, go IDLE.
  - HOLD, any rise bit set on an edge (including the ack edge): the event is dropped and overrun pulses for one cycle. Dropped events are not re-presented, even if the key stays down.
- Releases (falling deb) produce no events.
- Latency: raw level stable from before edge 1 gives a/en valid after edge DEB_CNT+3 (2 sync + DEB_CNT debounce + 1 capture). With DEB_CNT=4, that is edge 7.
- ack-to-release latency: 1 edge. A new press can be captured on the edge after the return to IDLE.
- Invariant: a is either 0 or exactly one-hot, and en==(a!=0) at all times.
- Reset mid-operation: a and en drop to 0 asynchronously. A key still held through reset release is seen as a fresh press and captured DEB_CNT+3 edges after release.

Decomposition:
- Shared package key_pkg:
  - NUM_KEYS=8, default DEB_CNT
  - state enum {IDLE, HOLD}
  - lowest-set-bit one-hot function
- Sub-module debounce_bit: one channel containing the 2-flop sync, counter and deb register. Parameter DEB_CNT; ports clk, rst, din, dout. Instantiated NUM_KEYS times by generate.
- Top level holds deb_prev, rise logic, FSM, a/en/overrun registers.

Test Plan:
- Reset: assert rst mid-cycle with key_in=8'hFF → a=8'h00, en=0, overrun=0 immediately. After release, expect capture a=8'h01 and en=1 at edge 7, plus an overrun pulse (7 simultaneous extra rises).
- Clean press: key_in=8'h20 held, DEB_CNT=4 → a=8'h20 and en=1 after edge 7. Both held until ack=1 for one edge, then a=8'h00 and en=0 on the next edge.
- Bounce: key_in[2] high 3 cycles, low 2, high 3 → no capture, en stays 0. Then hold high ≥ 4 cycles → a=8'h04.
- Simultaneous: key_in 8'h00→8'h48 in one cycle → a=8'h08 and overrun=1 for exactly one cycle. After ack, no further capture while both keys are held.
- Overrun in HOLD: key 0 captured, no ack; key_in[1] pressed and debounced → overrun pulse, a stays 8'h01. ack → idle, and key 1 (still held) is not captured.
- Reset during HOLD with key 3 held → a=0 and en=0 asynchronously. After release, a=8'h08 at edge DEB_CNT+3.
